param_serial_addsub: RTL and testbench
======================================

Name: param_serial_addsub

Overview:
Multi-cycle, digit-serial adder/subtractor. It is parametrised in operand width and in digits processed per clock. It is the sequential successor to the combinational parametrised subtractor and is used where area matters more than latency. It accepts one operation per start pulse, computes over SIZE/DIGIT cycles, and returns the result, carry/borrow and signed overflow with a one-cycle done pulse.

Parameters:
SIZE, 8, operand and result width in bits; must be ≥2.
DIGIT, 1, bits processed per RUN cycle; must divide SIZE exactly. Any other value is illegal and must trip an elaboration-time check.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled on rising edge.
sub  input  1  mode, sampled with start: 1 = a - b, 0 = a + b.
a  input  SIZE  operand A (unsigned or two's complement), sampled with start.
b  input  SIZE  operand B, sampled with start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse; result fields are valid.
result  output  SIZE  sum/difference modulo 2^SIZE.
carry_borrow  output  1  add: carry out of MSB. Sub: borrow, 1 iff a < b unsigned.
overflow  output  1  two's-complement overflow of the operation.

Behaviour:
- Reset (async, rst_n=0): FSM goes to IDLE. busy=0, done=0, result=0, carry_borrow=0, overflow=0. Internal operand registers, count and carry are cleared. Reset mid-RUN aborts the operation with no done pulse.
- FSM states are IDLE, RUN and DONE. N = SIZE/DIGIT.
- Transitions:
  - IDLE: start=1 → RUN.
  - RUN: stays N cycles, then → DONE.
  - DONE: lasts 1 cycle. start=1 → RUN (back-to-back); otherwise → IDLE.
- Accept: start is honoured only in IDLE or DONE. On accept, latch a and b into shift registers. Latch b_eff = sub ? ~b : b. Initialise carry = sub. Set count = 0.
- Start while busy=1 is ignored entirely. Operands are not resampled.
- Each RUN cycle:
  - Add the low DIGIT bits of A, the low DIGIT bits of b_eff and the carry.
  - Shift the DIGIT-bit sum into the result shift register from the top.
  - Shift the A and b_eff registers right by DIGIT.
  - Update the carry register with the digit carry-out.
  - Increment count.
- Latency: start accepted at edge k gives busy=1 for edges k+1 .. k+N and done=1 in the cycle after edge k+N. So done is visible N+1 cycles after the accepting edge.
- In DONE:
  - result holds the full SIZE-bit value.
  - carry_borrow = sub ? ~carry : carry.
  - overflow = (a[SIZE-1] == b_eff[SIZE-1]) && (result[SIZE-1] != a[SIZE-1]). Uses the latched original MSBs, which must be retained separately from the shift registers.
- Outputs result, carry_borrow and overflow update only on entry to DONE. They are held stable until the next DONE, including through IDLE and the following RUN.
- done is high for exactly one cycle per completed operation. busy and done are never high simultaneously.
- Arithmetic wraps modulo 2^SIZE. There is no saturation.

Test Plan:
- SIZE=8, DIGIT=1: start with sub=1, a=0x05, b=0x03 → done 9 cycles after the accepting edge; result=0x02, carry_borrow=0, overflow=0; busy high for exactly 8 cycles.
- SIZE=8, DIGIT=1:
  - sub=1, a=0x03, b=0x05 → result=0xFE, carry_borrow=1, overflow=0.
  - sub=1, a=0x80, b=0x01 → result=0x7F, carry_borrow=0, overflow=1.
- SIZE=8, DIGIT=4: sub=0, a=0xFF, b=0x01 → result=0x00, carry_borrow=1, overflow=0, done 3 cycles after accept. Then sub=0, a=0x7F, b=0x01 → 0x80, overflow=1.
- Handshake:
  - Pulse start again during RUN with different operands → ignored; first result is unchanged and exactly one done pulse occurs.
  - Start held high through DONE → back-to-back operation begins with no IDLE cycle.
- Reset: assert rst_n=0 asynchronously mid-RUN (e.g. cycle 4 of 8) → all outputs zero immediately with no done pulse. After release, a fresh op (sub=1, 0x0A-0x0A) gives result=0x00, carry_borrow=0.
- Sweep: SIZE=2, DIGIT=1, exhaustive a, b over 0..3 in both modes → every result, carry_borrow and overflow matches a reference model.

Source files
------------

// File: rtl/param_serial_addsub_if.sv
// param_serial_addsub_if: request/result bundle for the digit-serial adder/subtractor.
//   start, sub, a, b         : request side (master drives)
//   busy, done, result,
//   carry_borrow, overflow   : status/result side (slave drives)
interface param_serial_addsub_if #(parameter int SIZE = 8);
   logic            start;
   logic            sub;
   logic [SIZE-1:0] a;
   logic [SIZE-1:0] b;
   logic            busy;
   logic            done;
   logic [SIZE-1:0] result;
   logic            carry_borrow;
   logic            overflow;
   modport master (output start, sub, a, b, input busy, done, result, carry_borrow, overflow);
   modport slave  (input start, sub, a, b, output busy, done, result, carry_borrow, overflow);
endinterface

// File: rtl/param_serial_addsub.sv
// param_serial_addsub: multi-cycle digit-serial adder/subtractor, DIGIT bits per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of param_serial_addsub_if (start/sub/a/b in; busy/done/result/carry_borrow/overflow out)
module param_serial_addsub #(
   parameter int SIZE  = 8,
   parameter int DIGIT = 1
) (
   input logic                  clk,
   input logic                  rst_n,
   param_serial_addsub_if.slave bus
);
   localparam int DG = (DIGIT < 1) ? 1 : DIGIT;
   localparam int N  = SIZE / DG;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;

   generate
      if (SIZE < 2 || DIGIT < 1 || DIGIT > SIZE || (SIZE % DG) != 0) begin : g_bad_params
         $error("param_serial_addsub: SIZE must be >= 2 and DIGIT must divide SIZE");
      end
   endgenerate

   logic [1:0]      state;
   logic [SIZE-1:0] a_sh, b_sh, res_sh, res_nxt, result;
   logic [CW-1:0]   cnt;
   logic            carry, sub_q, a_msb, b_msb, carry_borrow, overflow;
   logic [DIGIT:0]  dsum;

   // one digit of the ripple; the new digit enters the result register from the top
   always_comb begin
      dsum    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + (DIGIT+1)'(carry);
      res_nxt = (res_sh >> DIGIT) | (SIZE'(dsum[DIGIT-1:0]) << (SIZE - DIGIT));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         a_sh         <= '0;
         b_sh         <= '0;
         res_sh       <= '0;
         cnt          <= '0;
         carry        <= 1'b0;
         sub_q        <= 1'b0;
         a_msb        <= 1'b0;
         b_msb        <= 1'b0;
         result       <= '0;
         carry_borrow <= 1'b0;
         overflow     <= 1'b0;
      end else if (bus.start && state != RUN) begin
         state <= RUN;
         a_sh  <= bus.a;
         b_sh  <= bus.sub ? ~bus.b : bus.b;
         carry <= bus.sub;
         sub_q <= bus.sub;
         // MSBs kept apart because the shift registers lose them during RUN
         a_msb <= bus.a[SIZE-1];
         b_msb <= bus.sub ^ bus.b[SIZE-1];
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sh   <= a_sh >> DIGIT;
         b_sh   <= b_sh >> DIGIT;
         res_sh <= res_nxt;
         carry  <= dsum[DIGIT];
         cnt    <= cnt + 1'b1;
         if (cnt == CW'(N - 1)) begin
            state        <= DONE;
            result       <= res_nxt;
            carry_borrow <= sub_q ^ dsum[DIGIT];
            overflow     <= (a_msb == b_msb) && (res_nxt[SIZE-1] != a_msb);
         end
      end else begin
         state <= IDLE;
      end
   end

   assign bus.busy         = (state == RUN);
   assign bus.done         = (state == DONE);
   assign bus.result       = result;
   assign bus.carry_borrow = carry_borrow;
   assign bus.overflow     = overflow;
endmodule

// File: tb/tb_param_serial_addsub.sv
// tb_param_serial_addsub: randomized and directed checks of param_serial_addsub in three configurations.
module tb_param_serial_addsub;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   param_serial_addsub_if #(.SIZE(8)) b8 ();
   param_serial_addsub_if #(.SIZE(8)) b84 ();
   param_serial_addsub_if #(.SIZE(2)) b2 ();

   param_serial_addsub #(.SIZE(8), .DIGIT(1)) u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
   param_serial_addsub #(.SIZE(8), .DIGIT(4)) u84 (.clk(clk), .rst_n(rst_n), .bus(b84));
   param_serial_addsub #(.SIZE(2), .DIGIT(1)) u2  (.clk(clk), .rst_n(rst_n), .bus(b2));

   task automatic set_in(input int d, input logic s, input logic m, input logic [7:0] x, input logic [7:0] y);
      case (d)
         0: begin b8.start = s; b8.sub = m; b8.a = x; b8.b = y; end
         1: begin b84.start = s; b84.sub = m; b84.a = x; b84.b = y; end
         default: begin b2.start = s; b2.sub = m; b2.a = x[1:0]; b2.b = y[1:0]; end
      endcase
   endtask

   task automatic get_out(input int d, output logic bz, output logic dn, output logic [7:0] r,
                          output logic cb, output logic ov);
      case (d)
         0: begin bz = b8.busy; dn = b8.done; r = b8.result; cb = b8.carry_borrow; ov = b8.overflow; end
         1: begin bz = b84.busy; dn = b84.done; r = b84.result; cb = b84.carry_borrow; ov = b84.overflow; end
         default: begin bz = b2.busy; dn = b2.done; r = {6'd0, b2.result}; cb = b2.carry_borrow; ov = b2.overflow; end
      endcase
   endtask

   // reference: exact integer arithmetic, returns {overflow, carry_borrow, result}
   function automatic logic [9:0] model(input int size, input logic m, input logic [7:0] x, input logic [7:0] y);
      int md, half, ux, uy, full, r, sx, sy, ex;
      logic cb, ov;
      md   = 1 << size;
      half = md / 2;
      ux   = int'(x) % md;
      uy   = int'(y) % md;
      full = m ? ux - uy : ux + uy;
      r    = (full + md) % md;
      cb   = m ? (ux < uy) : (full >= md);
      sx   = (ux >= half) ? ux - md : ux;
      sy   = (uy >= half) ? uy - md : uy;
      ex   = m ? sx - sy : sx + sy;
      ov   = (ex >= half) || (ex < -half);
      return {ov, cb, 8'(r)};
   endfunction

   // issue one op at #1 after an edge; lat counts samples from the one after the accepting edge
   task automatic run_op(input int d, input logic m, input logic [7:0] x, input logic [7:0] y,
                         output int lat, output int bc, output int both,
                         output logic [7:0] r, output logic cb, output logic ov);
      logic bz, dn;
      lat = -1; bc = 0; both = 0; r = 0; cb = 0; ov = 0;
      set_in(d, 1'b1, m, x, y);
      @(posedge clk); #1;
      set_in(d, 1'b0, m, x, y);
      for (int c = 1; c <= 40; c++) begin
         get_out(d, bz, dn, r, cb, ov);
         if (bz) bc++;
         if (bz && dn) both++;
         if (dn) begin
            lat = c;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      logic bz, dn, cb, ov;
      logic [7:0] r;
      for (int d = 0; d < 3; d++) set_in(d, 1'b0, 1'b0, 8'h00, 8'h00);
      rst_n = 1'b0;
      #12;
      for (int d = 0; d < 3; d++) begin
         get_out(d, bz, dn, r, cb, ov);
         checks++;
         if ({bz, dn, r, cb, ov} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state dut%0d: busy=%b done=%b result=%h cb=%b ov=%b, required all 0", d, bz, dn, r, cb, ov);
         end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_directed;
      int lat, bc, both;
      logic [7:0] r;
      logic cb, ov;
      run_op(0, 1'b1, 8'h05, 8'h03, lat, bc, both, r, cb, ov);
      checks++;
      if (lat !== 9 || bc !== 8 || both !== 0) begin
         errors++;
         $display("FAIL sub_05_03 timing: latency=%0d busy_cycles=%0d overlap=%0d, required 9/8/0", lat, bc, both);
      end
      checks++;
      if ({r, cb, ov} !== {8'h02, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL sub_05_03: result=%h cb=%b ov=%b, required 02/0/0", r, cb, ov);
      end
      run_op(0, 1'b1, 8'h03, 8'h05, lat, bc, both, r, cb, ov);
      checks++;
      if ({r, cb, ov} !== {8'hFE, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL sub_03_05: result=%h cb=%b ov=%b, required fe/1/0", r, cb, ov);
      end
      run_op(0, 1'b1, 8'h80, 8'h01, lat, bc, both, r, cb, ov);
      checks++;
      if ({r, cb, ov} !== {8'h7F, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL sub_80_01: result=%h cb=%b ov=%b, required 7f/0/1", r, cb, ov);
      end
   endtask

   task automatic test_digit4;
      int lat, bc, both;
      logic [7:0] r;
      logic cb, ov;
      run_op(1, 1'b0, 8'hFF, 8'h01, lat, bc, both, r, cb, ov);
      checks++;
      if (lat !== 3 || bc !== 2) begin
         errors++;
         $display("FAIL d4_timing: latency=%0d busy_cycles=%0d, required 3/2", lat, bc);
      end
      checks++;
      if ({r, cb, ov} !== {8'h00, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL d4_add_ff_01: result=%h cb=%b ov=%b, required 00/1/0", r, cb, ov);
      end
      run_op(1, 1'b0, 8'h7F, 8'h01, lat, bc, both, r, cb, ov);
      checks++;
      if ({r, cb, ov} !== {8'h80, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL d4_add_7f_01: result=%h cb=%b ov=%b, required 80/0/1", r, cb, ov);
      end
   endtask

   task automatic test_random;
      int lat, bc, both, n;
      logic [7:0] r, x, y;
      logic cb, ov, m;
      logic [9:0] exp;
      for (int i = 0; i < 40; i++) begin
         int d;
         d = i % 2;
         n = (d == 0) ? 8 : 2;
         m = 1'($urandom_range(0, 1));
         x = 8'($urandom);
         y = 8'($urandom);
         exp = model(8, m, x, y);
         run_op(d, m, x, y, lat, bc, both, r, cb, ov);
         checks++;
         if (lat !== n + 1 || bc !== n || both !== 0) begin
            errors++;
            $display("FAIL rand_timing dut%0d: latency=%0d busy=%0d overlap=%0d, required %0d/%0d/0", d, lat, bc, both, n + 1, n);
         end
         checks++;
         if ({ov, cb, r} !== exp) begin
            errors++;
            $display("FAIL rand dut%0d sub=%b a=%h b=%h: ov/cb/result=%b/%b/%h, required %b/%b/%h",
                     d, m, x, y, ov, cb, r, exp[9], exp[8], exp[7:0]);
         end
      end
   endtask

   task automatic test_ignore_start;
      int dones, both;
      logic [7:0] r, rd;
      logic bz, dn, cb, ov;
      dones = 0; both = 0; rd = 8'h00;
      set_in(0, 1'b1, 1'b0, 8'h10, 8'h20);
      @(posedge clk); #1;
      set_in(0, 1'b0, 1'b0, 8'h10, 8'h20);
      for (int c = 1; c <= 20; c++) begin
         set_in(0, c == 3, 1'b1, 8'hFF, 8'h7E);
         get_out(0, bz, dn, r, cb, ov);
         if (bz && dn) both++;
         if (dn) begin
            dones++;
            rd = r;
         end
         @(posedge clk); #1;
      end
      set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
      checks++;
      if (dones !== 1 || both !== 0) begin
         errors++;
         $display("FAIL ignore_start pulses: done_pulses=%0d overlap=%0d, required 1/0", dones, both);
      end
      checks++;
      if (rd !== 8'h30) begin
         errors++;
         $display("FAIL ignore_start result: got %h, required 30", rd);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      logic [7:0] r;
      logic bz, dn, cb, ov;
      lat = -1;
      set_in(0, 1'b1, 1'b0, 8'h21, 8'h13);
      @(posedge clk); #1;
      for (int c = 1; c <= 20; c++) begin
         get_out(0, bz, dn, r, cb, ov);
         if (dn) break;
         @(posedge clk); #1;
      end
      checks++;
      if (dn !== 1'b1 || r !== 8'h34) begin
         errors++;
         $display("FAIL b2b_first: done=%b result=%h, required 1/34", dn, r);
      end
      set_in(0, 1'b1, 1'b1, 8'h5A, 8'h11);
      @(posedge clk); #1;
      set_in(0, 1'b0, 1'b1, 8'h5A, 8'h11);
      get_out(0, bz, dn, r, cb, ov);
      checks++;
      if (bz !== 1'b1 || dn !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_idle: busy=%b done=%b, required 1/0", bz, dn);
      end
      checks++;
      if (r !== 8'h34) begin
         errors++;
         $display("FAIL b2b_hold_in_run: result=%h, required 34", r);
      end
      for (int c = 1; c <= 20; c++) begin
         get_out(0, bz, dn, r, cb, ov);
         if (dn) begin
            lat = c;
            break;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (lat !== 9 || {r, cb, ov} !== {8'h49, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL b2b_second: latency=%0d result=%h cb=%b ov=%b, required 9/49/0/0", lat, r, cb, ov);
      end
      @(posedge clk); #1;
      get_out(0, bz, dn, r, cb, ov);
      checks++;
      if (bz !== 1'b0 || dn !== 1'b0 || r !== 8'h49) begin
         errors++;
         $display("FAIL hold_in_idle: busy=%b done=%b result=%h, required 0/0/49", bz, dn, r);
      end
   endtask

   task automatic test_reset_mid_run;
      int lat, bc, both, dones;
      logic [7:0] r;
      logic bz, dn, cb, ov;
      dones = 0;
      set_in(0, 1'b1, 1'b0, 8'hF0, 8'h33);
      @(posedge clk); #1;
      set_in(0, 1'b0, 1'b0, 8'hF0, 8'h33);
      repeat (3) begin @(posedge clk); #1; end
      #2;
      rst_n = 1'b0;
      #1;
      get_out(0, bz, dn, r, cb, ov);
      checks++;
      if ({bz, dn, r, cb, ov} !== 12'h000) begin
         errors++;
         $display("FAIL reset_mid_run: busy=%b done=%b result=%h cb=%b ov=%b, required all 0", bz, dn, r, cb, ov);
      end
      repeat (2) begin
         @(posedge clk); #1;
         get_out(0, bz, dn, r, cb, ov);
         if (dn) dones++;
      end
      rst_n = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
         get_out(0, bz, dn, r, cb, ov);
         if (dn || bz) dones++;
      end
      checks++;
      if (dones !== 0) begin
         errors++;
         $display("FAIL reset_abort: %0d busy/done cycles after reset, required 0", dones);
      end
      run_op(0, 1'b1, 8'h0A, 8'h0A, lat, bc, both, r, cb, ov);
      checks++;
      if (lat !== 9 || {r, cb, ov} !== {8'h00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL post_reset_op: latency=%0d result=%h cb=%b ov=%b, required 9/00/0/0", lat, r, cb, ov);
      end
   endtask

   task automatic test_sweep_size2;
      int lat, bc, both;
      logic [7:0] r;
      logic cb, ov;
      logic [9:0] exp;
      for (int m = 0; m < 2; m++)
         for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++) begin
               exp = model(2, 1'(m), 8'(x), 8'(y));
               run_op(2, 1'(m), 8'(x), 8'(y), lat, bc, both, r, cb, ov);
               checks++;
               if (lat !== 3 || {ov, cb, r} !== exp) begin
                  errors++;
                  $display("FAIL sweep2 sub=%0d a=%0d b=%0d: lat=%0d ov/cb/result=%b/%b/%0d, required 3/%b/%b/%0d",
                           m, x, y, lat, ov, cb, r, exp[9], exp[8], exp[7:0]);
               end
            end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_digit4;
      test_random;
      test_ignore_start;
      test_back_to_back;
      test_reset_mid_run;
      test_sweep_size2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
